clause_issue_buffer: RTL and testbench

- Upstream feeder for the clause arbiter.
- Buffers clauses streamed one per cycle from the clause loader in a circular FIFO.
- Presents the oldest up-to-OUTPUT_CNT clauses, oldest first, plus their count.
- Retires the number of clauses the arbiter reports as accepted, and tracks problem load/drain completion with a small FSM.

---
 rtl/clause_issue_buffer.sv | 134 +++++++++++++
 tb/tb_clause_issue_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clause_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : clause_issue_buffer
// Desc     : Circular clause FIFO feeding the clause arbiter; presents the
//            oldest up-to-OUTPUT_CNT clauses and tracks load/drain completion.
// Revision : 1.0 - initial release
// ============================================================================
module clause_issue_buffer #(
    parameter int OUTPUT_CNT      = 4,
    parameter int CLAUSE_WIDTH    = 3,
    parameter int ELEMENT_BIT_CNT = 5,
    parameter int DEPTH           = 16,
    parameter int CNT_BITS        = $clog2(OUTPUT_CNT) + 1
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 flush_in,
    input  logic                                                 load_valid_in,
    input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0]              load_clause_in,
    input  logic                                                 load_last_in,
    output logic                                                 load_ready_out,
    output logic [OUTPUT_CNT-1:0][CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_out,
    output logic [CNT_BITS-1:0]                                  clause_cnt_out,
    input  logic [CNT_BITS-1:0]                                  clause_accept_in,
    output logic [$clog2(DEPTH):0]                               count_out,
    output logic                                                 empty_out,
    output logic                                                 full_out,
    output logic                                                 done_out
);

    localparam int C_W  = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_CW-1:0] C_DEPTH   = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_OUT_CNT = C_CW'(OUTPUT_CNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [C_W-1:0]      r_mem [DEPTH];
    logic [C_AW-1:0]     r_head;
    logic [C_AW-1:0]     r_tail;
    logic [C_CW-1:0]     r_count;
    state_t              r_state;
    state_t              w_state_next;

    logic                w_push;
    logic [CNT_BITS-1:0] w_clause_cnt;
    logic [CNT_BITS-1:0] w_eff;
    logic [C_CW-1:0]     w_count_next;

    // Readiness looks only at registered state so a same-cycle pop never opens space.
    assign load_ready_out = (r_count != C_DEPTH) &&
                            ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_push         = load_valid_in && load_ready_out;

    assign w_clause_cnt   = (r_count >= C_OUT_CNT) ? CNT_BITS'(OUTPUT_CNT)
                                                   : r_count[CNT_BITS-1:0];
    assign w_eff          = (clause_accept_in > w_clause_cnt) ? w_clause_cnt
                                                              : clause_accept_in;
    assign w_count_next   = r_count + C_CW'(w_push) - C_CW'(w_eff);

    assign clause_cnt_out = w_clause_cnt;
    assign count_out      = r_count;
    assign empty_out      = (r_count == '0);
    assign full_out       = (r_count == C_DEPTH);
    assign done_out       = (r_state == S_DONE);

    generate
        for (genvar i = 0; i < OUTPUT_CNT; i++) begin : g_lane
            localparam logic [C_AW-1:0] C_OFS = C_AW'(i);
            logic [C_AW-1:0] w_rd_addr;
            assign w_rd_addr     = r_head + C_OFS;
            assign clause_out[i] = (CNT_BITS'(i) < w_clause_cnt) ? r_mem[w_rd_addr] : '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push && !flush_in) begin
            r_mem[r_tail] <= load_clause_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
        end else if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            // Truncating the pop amount to pointer width keeps the wrap modulo DEPTH.
            r_head  <= r_head + C_AW'(w_eff);
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_next = load_last_in ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_push && load_last_in) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_count_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_clause_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clause_issue_buffer
// Desc     : Directed self-checking bench for clause_issue_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clause_issue_buffer;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush_in;
    logic             load_valid_in;
    logic [14:0]      load_clause_in;
    logic             load_last_in;
    logic             load_ready_out;
    logic [3:0][14:0] clause_out;
    logic [2:0]       clause_cnt_out;
    logic [2:0]       clause_accept_in;
    logic [4:0]       count_out;
    logic             empty_out;
    logic             full_out;
    logic             done_out;

    int r_vec_cnt  = 0;
    int r_miss_cnt = 0;

    clause_issue_buffer #(
        .OUTPUT_CNT      (4),
        .CLAUSE_WIDTH    (3),
        .ELEMENT_BIT_CNT (5),
        .DEPTH           (16),
        .CNT_BITS        (3)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .flush_in         (flush_in),
        .load_valid_in    (load_valid_in),
        .load_clause_in   (load_clause_in),
        .load_last_in     (load_last_in),
        .load_ready_out   (load_ready_out),
        .clause_out       (clause_out),
        .clause_cnt_out   (clause_cnt_out),
        .clause_accept_in (clause_accept_in),
        .count_out        (count_out),
        .empty_out        (empty_out),
        .full_out         (full_out),
        .done_out         (done_out)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_vec_cnt++;
        if (got !== exp) begin
            r_miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle, return inputs to idle.
    task automatic cyc(input logic v, input logic [14:0] d, input logic l,
                       input logic [2:0] acc, input logic fl);
        load_valid_in    = v;
        load_clause_in   = d;
        load_last_in     = l;
        clause_accept_in = acc;
        flush_in         = fl;
        @(posedge clock);
        #1;
        load_valid_in    = 1'b0;
        load_clause_in   = '0;
        load_last_in     = 1'b0;
        clause_accept_in = '0;
        flush_in         = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_vec({tag, "_lane"}, 64'(clause_out[i]), 64'h0);
        end
        check_vec({tag, "_cnt"},   64'(clause_cnt_out), 64'd0);
        check_vec({tag, "_count"}, 64'(count_out),      64'd0);
        check_vec({tag, "_empty"}, 64'(empty_out),      64'd1);
        check_vec({tag, "_full"},  64'(full_out),       64'd0);
        check_vec({tag, "_ready"}, 64'(load_ready_out), 64'd1);
        check_vec({tag, "_done"},  64'(done_out),       64'd0);
    endtask

    initial begin
        reset            = 1'b0;
        flush_in         = 1'b0;
        load_valid_in    = 1'b0;
        load_clause_in   = '0;
        load_last_in     = 1'b0;
        clause_accept_in = '0;
        #3;
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Fill and present
        cyc(1, 15'h0AAA, 0, 0, 0);
        cyc(1, 15'h0BBB, 0, 0, 0);
        cyc(1, 15'h0CCC, 0, 0, 0);
        check_vec("fill_cnt",   64'(clause_cnt_out), 64'd3);
        check_vec("fill_lane0", 64'(clause_out[0]),  64'h0AAA);
        check_vec("fill_lane1", 64'(clause_out[1]),  64'h0BBB);
        check_vec("fill_lane2", 64'(clause_out[2]),  64'h0CCC);
        check_vec("fill_lane3", 64'(clause_out[3]),  64'h0);
        check_vec("fill_count", 64'(count_out),      64'd3);

        // Partial accept with six queued
        cyc(1, 15'h0DDD, 0, 0, 0);
        cyc(1, 15'h0EEE, 0, 0, 0);
        cyc(1, 15'h0FFF, 0, 0, 0);
        check_vec("six_cnt",   64'(clause_cnt_out), 64'd4);
        check_vec("six_count", 64'(count_out),      64'd6);
        cyc(0, 15'h0, 0, 2, 0);
        check_vec("pacc_lane0", 64'(clause_out[0]),  64'h0CCC);
        check_vec("pacc_lane3", 64'(clause_out[3]),  64'h0FFF);
        check_vec("pacc_cnt",   64'(clause_cnt_out), 64'd4);
        check_vec("pacc_count", 64'(count_out),      64'd4);

        // Full, then simultaneous offer and accept
        cyc(0, 15'h0, 0, 0, 1);
        check_vec("flush1_empty", 64'(empty_out), 64'd1);
        for (int k = 0; k < 16; k++) begin
            cyc(1, 15'(15'h0100 + k), 0, 0, 0);
        end
        check_vec("full_full",  64'(full_out),       64'd1);
        check_vec("full_ready", 64'(load_ready_out), 64'd0);
        check_vec("full_count", 64'(count_out),      64'd16);
        cyc(1, 15'h5555, 0, 1, 0);
        check_vec("fpop_count", 64'(count_out),     64'd15);
        check_vec("fpop_lane0", 64'(clause_out[0]), 64'h0101);
        check_vec("fpop_full",  64'(full_out),      64'd0);
        cyc(1, 15'h5555, 0, 1, 0);
        check_vec("pp_count", 64'(count_out),     64'd15);
        check_vec("pp_lane0", 64'(clause_out[0]), 64'h0102);

        // Wrap: move head to 14 then queue five
        cyc(0, 15'h0, 0, 0, 1);
        for (int k = 0; k < 14; k++) begin
            cyc(1, 15'(15'h7000 + k), 0, 0, 0);
        end
        cyc(0, 15'h0, 0, 4, 0);
        cyc(0, 15'h0, 0, 4, 0);
        cyc(0, 15'h0, 0, 4, 0);
        cyc(0, 15'h0, 0, 2, 0);
        check_vec("wpre_count", 64'(count_out), 64'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 15'(15'h2000 + k), 0, 0, 0);
        end
        check_vec("wrap_count", 64'(count_out),      64'd5);
        check_vec("wrap_cnt",   64'(clause_cnt_out), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_vec("wrap_lane", 64'(clause_out[i]), 64'(15'h2000 + i));
        end
        cyc(0, 15'h0, 0, 4, 0);
        check_vec("wpop_lane0", 64'(clause_out[0]),  64'h2004);
        check_vec("wpop_cnt",   64'(clause_cnt_out), 64'd1);

        // Drain and done pulse
        cyc(0, 15'h0, 0, 0, 1);
        cyc(1, 15'h3000, 0, 0, 0);
        cyc(1, 15'h3001, 0, 0, 0);
        cyc(1, 15'h3002, 1, 0, 0);
        check_vec("drain_ready", 64'(load_ready_out), 64'd0);
        check_vec("drain_count", 64'(count_out),      64'd3);
        cyc(1, 15'h3333, 0, 2, 0);
        check_vec("drain_acc2_count", 64'(count_out),     64'd1);
        check_vec("drain_acc2_lane0", 64'(clause_out[0]), 64'h3002);
        check_vec("drain_acc2_done",  64'(done_out),      64'd0);
        cyc(0, 15'h0, 0, 1, 0);
        check_vec("done_pulse", 64'(done_out),       64'd1);
        check_vec("done_ready", 64'(load_ready_out), 64'd0);
        check_vec("done_count", 64'(count_out),      64'd0);
        cyc(0, 15'h0, 0, 0, 0);
        check_vec("idle_done",  64'(done_out),       64'd0);
        check_vec("idle_ready", 64'(load_ready_out), 64'd1);

        // Over-accept clamps
        cyc(1, 15'h4000, 0, 0, 0);
        cyc(1, 15'h4001, 0, 0, 0);
        cyc(0, 15'h0, 0, 4, 0);
        check_vec("oacc_count", 64'(count_out),      64'd0);
        check_vec("oacc_empty", 64'(empty_out),      64'd1);
        check_vec("oacc_cnt",   64'(clause_cnt_out), 64'd0);

        // Flush while draining
        cyc(1, 15'h4100, 0, 0, 0);
        cyc(1, 15'h4101, 0, 0, 0);
        cyc(1, 15'h4102, 1, 0, 0);
        check_vec("fdr_ready", 64'(load_ready_out), 64'd0);
        cyc(0, 15'h0, 0, 1, 1);
        check_vec("fdr_empty", 64'(empty_out),      64'd1);
        check_vec("fdr_done",  64'(done_out),       64'd0);
        check_vec("fdr_ready2", 64'(load_ready_out), 64'd1);
        cyc(0, 15'h0, 0, 0, 0);
        check_vec("fdr_done2", 64'(done_out), 64'd0);

        // Asynchronous reset mid-load, checked between clock edges
        cyc(1, 15'h4200, 0, 0, 0);
        cyc(1, 15'h4201, 0, 0, 0);
        check_vec("mid_count", 64'(count_out), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc(1, 15'h4300, 0, 0, 0);
        check_vec("post_lane0", 64'(clause_out[0]), 64'h4300);

        $display("== %0d vectors applied, %0d miscompares ==", r_vec_cnt, r_miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
